// File: rtl/proc_pkg.sv
// proc_pkg: bus transfer codes, NOP pattern, fetch FSM encoding and queue entry layout
package proc_pkg;
    localparam logic [1:0]  TRANS_IDLE = 2'b00;
    localparam logic [1:0]  TRANS_NSEQ = 2'b10;
    localparam logic [1:0]  TRANS_SEQ  = 2'b11;
    localparam logic [3:0]  COND_AL    = 4'b1110;
    localparam logic [31:0] NOP_INSTR  = {COND_AL, 28'h320F000};
    localparam logic [1:0]  ST_START   = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_HALT    = 2'd2;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        abort;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_prefetch_buffer_if.sv
// instruction_prefetch_buffer_if: memory read bus, branch redirect and decode handshake
interface instruction_prefetch_buffer_if;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] rdata;
    logic        abort;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_abort;
    logic        instr_valid;
    logic        instr_ready;
    modport master (
        output addr, trans, write, instr, instr_pc, instr_abort, instr_valid,
        input  rdata, abort, flush, flush_pc, instr_ready
    );
    modport slave (
        input  addr, trans, write, instr, instr_pc, instr_abort, instr_valid,
        output rdata, abort, flush, flush_pc, instr_ready
    );
endinterface

// File: rtl/instruction_prefetch_buffer_fifo.sv
// prefetch_fifo: power-of-two queue of fetched words with wrap-bit pointers and one-cycle flush
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ~flush & ((count != (AW+1)'(DEPTH)) | do_pop);

    // pointer update; flush empties the queue by catching the read pointer up
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // entry storage needs no reset since empty entries are never presented
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/instruction_prefetch_buffer.sv
// instruction_prefetch_buffer: sequential fetch engine feeding a queue that decode drains
module instruction_prefetch_buffer
    import proc_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                          clk,
    input  logic                          n_reset,
    instruction_prefetch_buffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    logic [1:0]   state;
    logic [31:0]  pc_next, req_pc;
    logic         inflight, push, pop, credit;
    logic [AW:0]  count;
    fetch_entry_t head;
    int           occupancy;

    assign bus.write       = 1'b0;
    assign bus.instr_valid = count != '0;
    assign bus.instr       = bus.instr_valid ? head.instr : NOP_INSTR;
    assign bus.instr_pc    = bus.instr_valid ? head.pc : 32'h0;
    assign bus.instr_abort = bus.instr_valid & head.abort;
    assign push            = inflight & ~bus.flush;
    assign pop             = bus.instr_valid & bus.instr_ready & ~bus.flush;

    // words that will hold a slot after this edge: queue plus both outstanding requests
    always_comb begin
        occupancy = int'(count) + int'(inflight) + int'(bus.trans != TRANS_IDLE) - int'(pop);
        credit    = occupancy < DEPTH;
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.flush),
        .din     ({bus.rdata, req_pc, bus.abort}),
        .dout    (head),
        .count   (count)
    );

    // fetch FSM; a flush presents its non-sequential request itself so a redirect costs no idle cycle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= ST_START;
            bus.addr  <= RESET_PC;
            bus.trans <= TRANS_IDLE;
            pc_next   <= RESET_PC;
            inflight  <= 1'b0;
            req_pc    <= 32'h0;
        end else begin
            inflight <= ~bus.flush & (bus.trans != TRANS_IDLE);
            req_pc   <= bus.addr;
            if (bus.flush) begin
                state     <= ST_RUN;
                bus.addr  <= bus.flush_pc;
                bus.trans <= TRANS_NSEQ;
                pc_next   <= bus.flush_pc + 32'd1;
            end else if (push && bus.abort) begin
                state     <= ST_HALT;
                bus.trans <= TRANS_IDLE;
            end else if (state == ST_START) begin
                state     <= ST_RUN;
                bus.addr  <= pc_next;
                bus.trans <= TRANS_NSEQ;
                pc_next   <= pc_next + 32'd1;
            end else if (state == ST_RUN && credit) begin
                bus.addr  <= pc_next;
                bus.trans <= TRANS_SEQ;
                pc_next   <= pc_next + 32'd1;
            end else begin
                bus.trans <= TRANS_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// tb_instruction_prefetch_buffer: directed scenarios against a one-cycle memory holding mem[i]=i+0x100
module tb_instruction_prefetch_buffer;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        abort_en = 1'b0;
    logic [31:0] abort_addr = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;

    instruction_prefetch_buffer_if bus();

    instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // memory answers every cycle with the word for last cycle's address
    always @(posedge clk) begin
        bus.rdata <= bus.addr + 32'h100;
        bus.abort <= abort_en && bus.trans != 2'b00 && bus.addr == abort_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want %h", bus.addr, 32'h0); end
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL reset_trans got %b want 00", bus.trans); end
        n_cmp++; if (bus.write !== 1'b0) begin n_err++; $display("FAIL reset_write got %b want 0", bus.write); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'hE320F000) begin n_err++; $display("FAIL reset_instr got %h want e320f000", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.instr_pc); end
        n_cmp++; if (bus.instr_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort got %b want 0", bus.instr_abort); end
        n_reset = 1'b1;
    endtask

    task automatic test_stream();
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL stream_c0_trans got %b want 00", bus.trans); end
        step();
        n_cmp++; if (bus.trans !== 2'b10) begin n_err++; $display("FAIL stream_c1_trans got %b want 10", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL stream_c1_addr got %h want 0", bus.addr); end
        step();
        n_cmp++; if (bus.trans !== 2'b11) begin n_err++; $display("FAIL stream_c2_trans got %b want 11", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h1) begin n_err++; $display("FAIL stream_c2_addr got %h want 1", bus.addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_c2_valid got %b want 0", bus.instr_valid); end
        step();
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.instr_valid); end
            n_cmp++; if (bus.instr_pc !== 32'(i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, bus.instr_pc, 32'(i)); end
            n_cmp++; if (bus.instr !== 32'(i) + 32'h100) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, bus.instr, 32'(i) + 32'h100); end
            n_cmp++; if (bus.trans !== 2'b11) begin n_err++; $display("FAIL stream_trans[%0d] got %b want 11", i, bus.trans); end
            step();
        end
    endtask

    task automatic test_stall();
        int issued = 0;
        bus.instr_ready = 1'b0;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h10;
        step();
        bus.flush = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (bus.trans !== 2'b00) begin
                n_cmp++; if (bus.addr !== 32'h10 + 32'(issued)) begin n_err++; $display("FAIL stall_req_addr[%0d] got %h want %h", issued, bus.addr, 32'h10 + 32'(issued)); end
                issued++;
            end
            step();
        end
        n_cmp++; if (issued !== 4) begin n_err++; $display("FAIL stall_issued got %0d want 4", issued); end
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL stall_trans got %b want 00", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h13) begin n_err++; $display("FAIL stall_addr_hold got %h want 13", bus.addr); end
        n_cmp++; if (bus.instr_pc !== 32'h10) begin n_err++; $display("FAIL stall_head_pc got %h want 10", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_drain_valid[%0d] got %b want 1", i, bus.instr_valid); end
            n_cmp++; if (bus.instr_pc !== 32'h10 + 32'(i)) begin n_err++; $display("FAIL stall_drain_pc[%0d] got %h want %h", i, bus.instr_pc, 32'h10 + 32'(i)); end
            n_cmp++; if (bus.instr !== 32'h110 + 32'(i)) begin n_err++; $display("FAIL stall_drain_instr[%0d] got %h want %h", i, bus.instr, 32'h110 + 32'(i)); end
            step();
        end
    endtask

    task automatic test_flush();
        bus.instr_ready = 1'b0;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h20;
        step();
        bus.flush = 1'b0;
        repeat (4) step();
        n_cmp++; if (bus.instr_pc !== 32'h20) begin n_err++; $display("FAIL flush_setup_pc got %h want 20", bus.instr_pc); end
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL flush_setup_trans got %b want 00", bus.trans); end
        bus.flush = 1'b1;
        bus.flush_pc = 32'h40;
        step();
        bus.flush = 1'b0;
        bus.instr_ready = 1'b1;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.trans !== 2'b10) begin n_err++; $display("FAIL flush_trans got %b want 10", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h40) begin n_err++; $display("FAIL flush_addr got %h want 40", bus.addr); end
        step();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_c2_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.addr !== 32'h41) begin n_err++; $display("FAIL flush_c2_addr got %h want 41", bus.addr); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h40) begin n_err++; $display("FAIL flush_first_pc got %h want 40", bus.instr_pc); end
        n_cmp++; if (bus.instr !== 32'h140) begin n_err++; $display("FAIL flush_first_instr got %h want 140", bus.instr); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h41) begin n_err++; $display("FAIL flush_second_pc got %h want 41", bus.instr_pc); end
    endtask

    task automatic test_back_to_back();
        bus.flush = 1'b1;
        bus.flush_pc = 32'h50;
        step();
        n_cmp++; if (bus.addr !== 32'h50) begin n_err++; $display("FAIL b2b_first_addr got %h want 50", bus.addr); end
        bus.flush_pc = 32'h60;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.trans !== 2'b10) begin n_err++; $display("FAIL b2b_trans got %b want 10", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h60) begin n_err++; $display("FAIL b2b_addr got %h want 60", bus.addr); end
        step();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL b2b_dropped_valid got %b want 0", bus.instr_valid); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h60) begin n_err++; $display("FAIL b2b_first_pc got %h want 60", bus.instr_pc); end
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got %b want 1", bus.instr_valid); end
    endtask

    task automatic test_abort();
        logic [1:0] exp_trans;
        logic       exp_valid;
        abort_en = 1'b1;
        abort_addr = 32'h5;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h0;
        step();
        bus.flush = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            exp_trans = (j == 1) ? 2'b10 : (j <= 7) ? 2'b11 : 2'b00;
            exp_valid = j >= 3 && j <= 9;
            n_cmp++; if (bus.trans !== exp_trans) begin n_err++; $display("FAIL abort_trans[c%0d] got %b want %b", j, bus.trans, exp_trans); end
            n_cmp++; if (bus.instr_valid !== exp_valid) begin n_err++; $display("FAIL abort_valid[c%0d] got %b want %b", j, bus.instr_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (bus.instr_pc !== 32'(j - 3)) begin n_err++; $display("FAIL abort_pc[c%0d] got %h want %h", j, bus.instr_pc, 32'(j - 3)); end
                n_cmp++; if (bus.instr_abort !== (j == 8)) begin n_err++; $display("FAIL abort_flag[c%0d] got %b want %b", j, bus.instr_abort, j == 8); end
            end
            step();
        end
        abort_en = 1'b0;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h0;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.trans !== 2'b10) begin n_err++; $display("FAIL abort_resume_trans got %b want 10", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL abort_resume_addr got %h want 0", bus.addr); end
        step();
        step();
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL abort_resume_valid got %b want 1", bus.instr_valid); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL abort_resume_pc got %h want 0", bus.instr_pc); end
        n_cmp++; if (bus.instr_abort !== 1'b0) begin n_err++; $display("FAIL abort_resume_flag got %b want 0", bus.instr_abort); end
    endtask

    task automatic test_flush_pop_full();
        bus.instr_ready = 1'b0;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h80;
        step();
        bus.flush = 1'b0;
        repeat (5) step();
        n_cmp++; if (bus.instr_pc !== 32'h80) begin n_err++; $display("FAIL full_head_pc got %h want 80", bus.instr_pc); end
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL full_trans got %b want 00", bus.trans); end
        bus.flush = 1'b1;
        bus.flush_pc = 32'h90;
        bus.instr_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL full_flush_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.addr !== 32'h90) begin n_err++; $display("FAIL full_flush_addr got %h want 90", bus.addr); end
        step();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL full_stale_valid got %b want 0", bus.instr_valid); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h90) begin n_err++; $display("FAIL full_first_pc got %h want 90", bus.instr_pc); end
        n_cmp++; if (bus.instr !== 32'h190) begin n_err++; $display("FAIL full_first_instr got %h want 190", bus.instr); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h91) begin n_err++; $display("FAIL full_second_pc got %h want 91", bus.instr_pc); end
    endtask

    task automatic test_async_reset();
        step();
        n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid got %b want 1", bus.instr_valid); end
        n_reset = 1'b0;
        #1;
        n_cmp++; if (bus.trans !== 2'b00) begin n_err++; $display("FAIL areset_trans got %b want 00", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL areset_addr got %h want 0", bus.addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 32'hE320F000) begin n_err++; $display("FAIL areset_instr got %h want e320f000", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL areset_pc got %h want 0", bus.instr_pc); end
        step();
        n_reset = 1'b1;
        step();
        n_cmp++; if (bus.trans !== 2'b10) begin n_err++; $display("FAIL areset_restart_trans got %b want 10", bus.trans); end
        n_cmp++; if (bus.addr !== 32'h0) begin n_err++; $display("FAIL areset_restart_addr got %h want 0", bus.addr); end
        step();
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_pending_valid got %b want 0", bus.instr_valid); end
        step();
        n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL areset_first_pc got %h want 0", bus.instr_pc); end
        n_cmp++; if (bus.instr !== 32'h100) begin n_err++; $display("FAIL areset_first_instr got %h want 100", bus.instr); end
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.flush_pc = 32'h0;
        bus.instr_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_back_to_back();
        test_abort();
        test_flush_pop_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
